irq_aggregator: RTL and testbench
=================================

// Module: irq_aggregator
// PURPOSE
//  Avalon-MM slave that collects the irq outputs of the interval timers and other peripherals.
//  Latches, masks and prioritises them, and drives one combined irq to the Nios II/uC-OS-II CPU.
//  Sits directly downstream of the timer: the timer irq is wired to one irq_in bit.
//  Software reads ACTIVE to find the serviced source, then clears it through ACK or PENDING.
// PARAMETERS
//  N_IRQ   8   number of interrupt inputs (1..15); source id = bit index
// PORTS
//  clk        in   1      system clock; single clock domain
//  reset      in   1      synchronous, active-high reset
//  address    in   3      register select
//  chipselect in   1      slave select
//  write_n    in   1      active-low write strobe
//  writedata  in   16     write data
//  irq_in     in   N_IRQ  source interrupt lines, synchronous to clk
//  readdata   out  16     registered read data
//  irq        out  1      combined interrupt to CPU
// BEHAVIOUR
//  Write strobe: chipselect && !write_n. Unimplemented bits write-ignored, read 0.
//  Register map (address: name, access):
//    0 PENDING  R/W1C: pending[N_IRQ-1:0]
//    1 ENABLE   RW: per-source mask
//    2 MODE     RW: 1=rising-edge source, 0=level source
//    3 ACTIVE   R: {valid[15], 11'b0, id[3:0]}; 0x0000 when none
//    4 RAW      R: irq_in
//    5 ACK      W: writedata[3:0]=id clears that edge source's pending; reads 0
//    6 OVERRUN  R/W1C: per-source lost-event flag
//    7 CONTROL  RW: bit0 = global enable
//  Reset: PENDING, ENABLE, MODE, OVERRUN, CONTROL, readdata and irq all 0.
//  irq_d (previous irq_in) loads irq_in every cycle, including during reset.
//    Consequence: a line already high at reset release produces no edge.
//  Edge sources: rise = irq_in & ~irq_d sets pending on the same clock edge.
//    Set beats clear: a rise coinciding with a W1C/ACK clear of that bit leaves pending = 1.
//    A rise while pending is already 1 sets OVERRUN for that bit.
//    Set beats W1C on OVERRUN in the same cycle.
//  Level sources: pending <= irq_in every cycle; W1C/ACK have no effect; OVERRUN never set.
//  MODE write: pending of each bit whose mode changes is cleared in that cycle.
//    The next cycle then follows the new mode.
//  ACTIVE: lowest-index bit of (pending & ENABLE) wins, combinational from the registers.
//    ACK with id >= N_IRQ is ignored. ACK of a level source is ignored.
//  irq <= CONTROL[0] && |(pending & ENABLE), registered.
//    Latency: source rises at edge k -> pending after k -> irq after k+1.
//    Clear/mask/disable: irq drops 1 cycle after the write edge.
//  readdata <= mux(address) every clock, independent of chipselect (1-cycle read latency).
//    The mux uses pre-write register values, so a same-cycle write is not visible.
// TESTING
//  1 Reset with irq_in=0x01 held, MODE stays 0 -> after release PENDING=0x0001, irq=0, all other regs 0.
//  2 MODE=0x00FF, ENABLE=0x0004, CONTROL=1; 1-cycle pulse on irq_in[2] -> PENDING=0x0004,
//    irq=1 two edges later; ACK write 2 -> irq=0 next cycle.
//  3 Edge pending 0x0028, ENABLE=0x00FF -> ACTIVE=0x8003; ACK 3 -> ACTIVE=0x8005; ACK 5 -> 0x0000.
//  4 W1C PENDING=0x0001 in same cycle as new rise on bit0 -> PENDING bit0 stays 1, OVERRUN=0x0000.
//  5 Two pulses on edge bit1 without clear -> OVERRUN=0x0002; W1C OVERRUN=0x0002 -> 0x0000.
//  6 Level bit4 enabled, irq_in[4]=1 -> W1C 0x0010 no effect; drop irq_in[4] -> irq=0 two cycles later.
//    Re-raise, then ENABLE=0 -> irq=0 next cycle.

Source files
------------

// File: rtl/irq_aggregator_if.sv
// Avalon-MM slave bus for the interrupt aggregator register file.
interface irq_aggregator_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/irq_aggregator.sv
// Latches, masks and prioritises peripheral interrupt lines into one CPU irq,
// with an Avalon-MM register file for pending/enable/mode/ack/overrun control.
module irq_aggregator #(
    parameter int N_IRQ = 8
) (
    input  logic             clk,
    input  logic             reset,
    irq_aggregator_if.slave  bus,
    input  logic [N_IRQ-1:0] irq_in,
    output logic             irq
);
    logic [N_IRQ-1:0] r_pending, r_enable, r_mode, r_overrun, r_irq_d;
    logic             r_ctrl;
    logic             r_irq;
    logic [15:0]      r_readdata;

    logic             w_wr;
    logic [N_IRQ-1:0] w_rise, w_w1c_pend, w_w1c_ovr, w_ack, w_mode_chg;
    logic [N_IRQ-1:0] w_pend_nxt, w_ovr_nxt, w_masked;
    logic [15:0]      w_active, w_rdmux;

    always_comb begin
        w_wr       = bus.chipselect && !bus.write_n;
        w_rise     = irq_in & ~r_irq_d;
        w_w1c_pend = (w_wr && bus.address == 3'd0) ? bus.writedata[N_IRQ-1:0] : '0;
        w_w1c_ovr  = (w_wr && bus.address == 3'd6) ? bus.writedata[N_IRQ-1:0] : '0;
        w_mode_chg = (w_wr && bus.address == 3'd2) ? (bus.writedata[N_IRQ-1:0] ^ r_mode) : '0;
        // Ids at or above N_IRQ match no bit, so such ACKs fall through harmlessly.
        w_ack = '0;
        for (int i = 0; i < N_IRQ; i++)
            w_ack[i] = w_wr && bus.address == 3'd5 && bus.writedata[3:0] == 4'(i);

        // Edge: a rise beats any clear. Level: track the line. Mode change: clear.
        w_pend_nxt = ~w_mode_chg &
                     ((r_mode & (w_rise | (r_pending & ~(w_w1c_pend | w_ack)))) |
                      (~r_mode & irq_in));
        w_ovr_nxt  = (r_mode & w_rise & r_pending) | (r_overrun & ~w_w1c_ovr);
    end

    always_comb begin
        w_masked = r_pending & r_enable;
        w_active = 16'h0000;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (w_masked[i]) w_active = {1'b1, 11'b0, 4'(i)};
    end

    always_comb begin
        w_rdmux = 16'h0000;
        case (bus.address)
            3'd0: w_rdmux = 16'(r_pending);
            3'd1: w_rdmux = 16'(r_enable);
            3'd2: w_rdmux = 16'(r_mode);
            3'd3: w_rdmux = w_active;
            3'd4: w_rdmux = 16'(irq_in);
            3'd6: w_rdmux = 16'(r_overrun);
            3'd7: w_rdmux = {15'b0, r_ctrl};
            default: w_rdmux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        // Edge history keeps loading through reset so a line held high across
        // reset release is not mistaken for a new event.
        r_irq_d <= irq_in;
        if (reset) begin
            r_pending  <= '0;
            r_enable   <= '0;
            r_mode     <= '0;
            r_overrun  <= '0;
            r_ctrl     <= 1'b0;
            r_irq      <= 1'b0;
            r_readdata <= 16'h0000;
        end else begin
            r_pending  <= w_pend_nxt;
            r_overrun  <= w_ovr_nxt;
            r_irq      <= r_ctrl && |w_masked;
            r_readdata <= w_rdmux;
            if (w_wr && bus.address == 3'd1) r_enable <= bus.writedata[N_IRQ-1:0];
            if (w_wr && bus.address == 3'd2) r_mode   <= bus.writedata[N_IRQ-1:0];
            if (w_wr && bus.address == 3'd7) r_ctrl   <= bus.writedata[0];
        end
    end

    assign bus.readdata = r_readdata;
    assign irq          = r_irq;
endmodule

// File: tb/tb_irq_aggregator.sv
// Directed bench for irq_aggregator: stimulus pushes expected readdata/irq
// values stamped with the cycle they become valid; a monitor pops and compares.
module tb_irq_aggregator;
    localparam int N_IRQ = 8;

    logic             clk;
    logic             reset;
    logic [N_IRQ-1:0] irq_in;
    logic             irq;
    int               cyc;
    bit               done;
    int               checks;
    int               failures;

    typedef struct {
        bit          kind;   // 0: readdata, 1: irq
        logic [15:0] exp;
        int          due;
        string       name;
    } exp_t;
    exp_t q[$];

    irq_aggregator_if bus ();

    irq_aggregator #(.N_IRQ(N_IRQ)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .irq_in (irq_in),
        .irq    (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: stimulus did not complete, expected completion before 200000");
        $fatal(1, "watchdog");
    end

    // Monitor: sole owner of the check/failure counters.
    initial begin
        checks   = 0;
        failures = 0;
    end
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t        e;
            logic [15:0] act;
            e   = q.pop_front();
            act = e.kind ? {15'b0, irq} : bus.readdata;
            checks++;
            if (e.due != cyc || act !== e.exp) begin
                failures++;
                $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)",
                         e.name, act, e.exp, cyc, e.due);
            end
        end
        if (done) begin
            while (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                failures++;
                $display("FAIL %s: never checked, expected %h", e.name, e.exp);
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit kind, input logic [15:0] exp, input int due, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.due  = due;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    // Write that also checks readdata captured on the write edge (pre-write value).
    task automatic wrc(input logic [2:0] a, input logic [15:0] d, input logic [15:0] exp, input string name);
        push(1'b0, exp, cyc + 1, name);
        wr(a, d);
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        push(1'b0, exp, cyc + 1, name);
        tick();
        bus.chipselect = 1'b0;
    endtask

    task automatic chk_irq(input logic e, input string name);
        push(1'b1, {15'b0, e}, cyc, name);
    endtask

    initial begin
        done           = 1'b0;
        reset          = 1'b1;
        irq_in         = 8'h01;
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 16'h0000;
        tick();
        tick();

        // Reset state; bit0 held high, level mode tracks it after release
        chk_irq(1'b0, "rst_irq");
        rd(3'd0, 16'h0000, "rst_readdata");
        reset = 1'b0;
        tick();
        rd(3'd0, 16'h0001, "t1_pending");
        rd(3'd1, 16'h0000, "t1_enable");
        rd(3'd2, 16'h0000, "t1_mode");
        rd(3'd3, 16'h0000, "t1_active");
        rd(3'd4, 16'h0001, "t1_raw");
        rd(3'd5, 16'h0000, "t1_ack_read");
        rd(3'd6, 16'h0000, "t1_overrun");
        rd(3'd7, 16'h0000, "t1_control");
        chk_irq(1'b0, "t1_irq");
        irq_in = 8'h00;

        // Edge pulse on bit2 -> pending, irq two edges later, ACK drops it
        wr(3'd2, 16'h00FF);
        wr(3'd1, 16'h0004);
        wr(3'd7, 16'h0001);
        irq_in = 8'h04;
        tick();
        irq_in = 8'h00;
        chk_irq(1'b0, "t2_irq_lat");
        rd(3'd0, 16'h0004, "t2_pending");
        chk_irq(1'b1, "t2_irq");
        wr(3'd5, 16'h0002);
        chk_irq(1'b1, "t2_ack_edge");
        tick();
        chk_irq(1'b0, "t2_ack_irq");
        rd(3'd0, 16'h0000, "t2_pending_clr");

        // Priority of ACTIVE and ACK walk-down, out-of-range ACK ignored
        wr(3'd1, 16'h00FF);
        irq_in = 8'h28;
        tick();
        irq_in = 8'h00;
        rd(3'd3, 16'h8003, "t3_active3");
        wr(3'd5, 16'h0003);
        rd(3'd3, 16'h8005, "t3_active5");
        wr(3'd5, 16'h0008);
        rd(3'd3, 16'h8005, "t3_ack_oob");
        wr(3'd5, 16'h0005);
        rd(3'd3, 16'h0000, "t3_active_none");

        // Rise beats W1C on pending
        irq_in = 8'h01;
        wr(3'd0, 16'h0001);
        irq_in = 8'h00;
        rd(3'd0, 16'h0001, "t4_pending");
        rd(3'd6, 16'h0000, "t4_overrun");
        wr(3'd0, 16'h0001);
        rd(3'd0, 16'h0000, "t4_w1c");

        // Overrun on second rise, W1C clears; then rise beats overrun W1C
        irq_in = 8'h02;
        tick();
        irq_in = 8'h00;
        tick();
        irq_in = 8'h02;
        tick();
        irq_in = 8'h00;
        rd(3'd6, 16'h0002, "t5_overrun");
        rd(3'd0, 16'h0002, "t5_pending");
        wr(3'd6, 16'h0002);
        rd(3'd6, 16'h0000, "t5_ovr_w1c");
        wr(3'd0, 16'h0002);
        rd(3'd0, 16'h0000, "t5_pend_w1c");
        irq_in = 8'h02;
        tick();
        irq_in = 8'h00;
        tick();
        irq_in = 8'h02;
        wr(3'd6, 16'h0002);
        irq_in = 8'h00;
        rd(3'd6, 16'h0002, "t5_ovr_set_wins");
        wr(3'd6, 16'h0002);
        wr(3'd0, 16'h0002);

        // Level source bit4
        wr(3'd2, 16'h00EF);
        wr(3'd1, 16'h0010);
        irq_in = 8'h10;
        tick();
        tick();
        chk_irq(1'b1, "t6_level_irq");
        wr(3'd0, 16'h0010);
        rd(3'd0, 16'h0010, "t6_w1c_noeffect");
        wr(3'd5, 16'h0004);
        rd(3'd0, 16'h0010, "t6_ack_noeffect");
        rd(3'd6, 16'h0000, "t6_no_overrun");
        irq_in = 8'h00;
        chk_irq(1'b1, "t6_drop_0");
        tick();
        chk_irq(1'b1, "t6_drop_1");
        tick();
        chk_irq(1'b0, "t6_drop_2");
        irq_in = 8'h10;
        tick();
        tick();
        chk_irq(1'b1, "t6_reraise");
        wrc(3'd1, 16'h0000, 16'h0010, "t6_rd_prewrite");
        chk_irq(1'b1, "t6_mask_edge");
        tick();
        chk_irq(1'b0, "t6_mask");

        // Global disable
        wr(3'd1, 16'h0010);
        tick();
        chk_irq(1'b1, "t7_enabled");
        wr(3'd7, 16'h0000);
        tick();
        chk_irq(1'b0, "t7_ctrl_off");

        // Mode change clears pending; held-high line makes no edge afterwards
        wr(3'd2, 16'h00FF);
        rd(3'd0, 16'h0000, "t8_mode_clr");
        rd(3'd0, 16'h0000, "t8_no_edge");
        irq_in = 8'h00;
        tick();
        tick();
        done = 1'b1;
    end
endmodule
